// File: rtl/fft_pkg.sv
// Shared constants and types for the radix-2 FFT/IFFT datapath.
package fft_pkg;

    localparam int unsigned CPLX_W    = 16;
    localparam int unsigned TWID_W    = 12;
    localparam int unsigned TWID_FRAC = 10;

    typedef struct packed {
        logic signed [CPLX_W-1:0] re;
        logic signed [CPLX_W-1:0] im;
    } cplx_t;

    // Conjugate twiddles W8^-k in Q2.10, indexed by k
    localparam logic signed [TWID_W-1:0] W8C_REAL [4] = '{12'sd1024, 12'sd724, 12'sd0,    -12'sd724};
    localparam logic signed [TWID_W-1:0] W8C_IMG  [4] = '{12'sd0,    12'sd724, 12'sd1024,  12'sd724};

endpackage

// File: rtl/inv_twiddle_rom.sv
// Combinational lookup of the conjugate twiddle (Tr, Ti) for index k.
module inv_twiddle_rom
    import fft_pkg::*;
(
    input  logic        [1:0]        k_i,
    output logic signed [TWID_W-1:0] tr_o,
    output logic signed [TWID_W-1:0] ti_o
);

    assign tr_o = W8C_REAL[k_i];
    assign ti_o = W8C_IMG[k_i];

endmodule

// File: rtl/ifft_twiddle_rotator.sv
// IFFT twiddle-multiply stage: 2-deep valid/ready pipeline, round half-up, saturate.
// Define INV_TWID_SCALE_EN to add a divide-by-2 per stage (1/8 normalisation over three stages).
module ifft_twiddle_rotator
    import fft_pkg::*;
#(
    parameter int unsigned DATA_W    = 16,
    parameter int unsigned FRAME_LEN = 8
) (
    input  logic                     CLK,
    input  logic                     RST,
    input  logic        [1:0]        Stage,
    input  logic                     In_Valid,
    output logic                     In_Ready,
    input  logic signed [DATA_W-1:0] In_Real,
    input  logic signed [DATA_W-1:0] In_Img,
    input  logic                     In_Last,
    output logic                     Out_Valid,
    input  logic                     Out_Ready,
    output logic signed [DATA_W-1:0] Out_Real,
    output logic signed [DATA_W-1:0] Out_Img,
    output logic                     Out_Last,
    output logic                     Frame_Err
);

    localparam int unsigned CNT_W  = 3;
    localparam int unsigned PROD_W = DATA_W + TWID_W;
    localparam int unsigned ACC_W  = PROD_W + 2;
`ifdef INV_TWID_SCALE_EN
    localparam int unsigned SHIFT  = TWID_FRAC + 1;
`else
    localparam int unsigned SHIFT  = TWID_FRAC;
`endif
    localparam logic [CNT_W-1:0]        LAST_POS = CNT_W'(FRAME_LEN - 1);
    localparam logic signed [ACC_W-1:0] RND      = ACC_W'(2 ** (SHIFT - 1));
    localparam logic signed [ACC_W-1:0] SAT_MAX  = ACC_W'(2 ** (DATA_W - 1) - 1);
    localparam logic signed [ACC_W-1:0] SAT_MIN  = ACC_W'(-(2 ** (DATA_W - 1)));

    logic                     p1_valid_q, p1_valid_d;
    logic signed [DATA_W-1:0] p1_re_q, p1_re_d;
    logic signed [DATA_W-1:0] p1_im_q, p1_im_d;
    logic signed [TWID_W-1:0] p1_tr_q, p1_tr_d;
    logic signed [TWID_W-1:0] p1_ti_q, p1_ti_d;
    logic                     p1_last_q, p1_last_d;
    logic                     out_valid_q, out_valid_d;
    logic signed [DATA_W-1:0] out_re_q, out_re_d;
    logic signed [DATA_W-1:0] out_im_q, out_im_d;
    logic                     out_last_q, out_last_d;
    logic                     frame_err_q, frame_err_d;
    logic [CNT_W-1:0]         n_q, n_d;

    logic                     advance_c;
    logic                     accept_c;
    logic [1:0]               k_c;
    logic signed [TWID_W-1:0] tr_c, ti_c;
    logic signed [PROD_W-1:0] rr_c, ii_c, ri_c, ir_c;
    logic signed [ACC_W-1:0]  pr_c, pi_c, pr_sh_c, pi_sh_c;

    function automatic logic signed [DATA_W-1:0] sat_f(input logic signed [ACC_W-1:0] v);
        logic signed [DATA_W-1:0] r;
        if (v > SAT_MAX) begin
            r = DATA_W'(SAT_MAX);
        end else if (v < SAT_MIN) begin
            r = DATA_W'(SAT_MIN);
        end else begin
            r = DATA_W'(v);
        end
        return r;
    endfunction

    assign advance_c = !out_valid_q || Out_Ready;
    assign accept_c  = In_Valid && advance_c;
    assign In_Ready  = advance_c;

    // Twiddle index from frame position and stage
    always_comb begin
        k_c = 2'd0;
        case (Stage)
            2'd0: if (n_q[2]) k_c = n_q[1:0];
            2'd1: if (n_q[1]) k_c = {n_q[0], 1'b0};
            default: k_c = 2'd0;
        endcase
    end

    inv_twiddle_rom u_rom (
        .k_i  (k_c),
        .tr_o (tr_c),
        .ti_o (ti_c)
    );

    // Complex multiply, then round half-up and arithmetic shift
    always_comb begin
        rr_c    = PROD_W'(p1_re_q) * PROD_W'(p1_tr_q);
        ii_c    = PROD_W'(p1_im_q) * PROD_W'(p1_ti_q);
        ri_c    = PROD_W'(p1_re_q) * PROD_W'(p1_ti_q);
        ir_c    = PROD_W'(p1_im_q) * PROD_W'(p1_tr_q);
        pr_c    = ACC_W'(rr_c) - ACC_W'(ii_c) + RND;
        pi_c    = ACC_W'(ri_c) + ACC_W'(ir_c) + RND;
        pr_sh_c = pr_c >>> SHIFT;
        pi_sh_c = pi_c >>> SHIFT;
    end

    always_comb begin
        p1_valid_d  = p1_valid_q;
        p1_re_d     = p1_re_q;
        p1_im_d     = p1_im_q;
        p1_tr_d     = p1_tr_q;
        p1_ti_d     = p1_ti_q;
        p1_last_d   = p1_last_q;
        out_valid_d = out_valid_q;
        out_re_d    = out_re_q;
        out_im_d    = out_im_q;
        out_last_d  = out_last_q;
        frame_err_d = 1'b0;
        n_d         = n_q;

        if (advance_c) begin
            p1_valid_d  = In_Valid;
            out_valid_d = p1_valid_q;
            if (In_Valid) begin
                p1_re_d   = In_Real;
                p1_im_d   = In_Img;
                p1_tr_d   = tr_c;
                p1_ti_d   = ti_c;
                p1_last_d = In_Last;
            end
            if (p1_valid_q) begin
                out_re_d   = sat_f(pr_sh_c);
                out_im_d   = sat_f(pi_sh_c);
                out_last_d = p1_last_q;
            end
        end

        // Frame position; a mismatch between In_Last and the final slot is flagged and resyncs
        if (accept_c) begin
            if (In_Last || (n_q == LAST_POS)) begin
                n_d         = '0;
                frame_err_d = In_Last ^ (n_q == LAST_POS);
            end else begin
                n_d = n_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            p1_valid_q  <= 1'b0;
            p1_re_q     <= '0;
            p1_im_q     <= '0;
            p1_tr_q     <= '0;
            p1_ti_q     <= '0;
            p1_last_q   <= 1'b0;
            out_valid_q <= 1'b0;
            out_re_q    <= '0;
            out_im_q    <= '0;
            out_last_q  <= 1'b0;
            frame_err_q <= 1'b0;
            n_q         <= '0;
        end else begin
            p1_valid_q  <= p1_valid_d;
            p1_re_q     <= p1_re_d;
            p1_im_q     <= p1_im_d;
            p1_tr_q     <= p1_tr_d;
            p1_ti_q     <= p1_ti_d;
            p1_last_q   <= p1_last_d;
            out_valid_q <= out_valid_d;
            out_re_q    <= out_re_d;
            out_im_q    <= out_im_d;
            out_last_q  <= out_last_d;
            frame_err_q <= frame_err_d;
            n_q         <= n_d;
        end
    end

    assign Out_Valid = out_valid_q;
    assign Out_Real  = out_re_q;
    assign Out_Img   = out_im_q;
    assign Out_Last  = out_last_q;
    assign Frame_Err = frame_err_q;

endmodule

// File: tb/tb_ifft_twiddle_rotator.sv
// Scoreboard bench for ifft_twiddle_rotator: directed cases plus randomized traffic and backpressure.
module tb_ifft_twiddle_rotator;
    import fft_pkg::*;

    localparam int DW = 16;
`ifdef INV_TWID_SCALE_EN
    localparam int SH = 11;
`else
    localparam int SH = 10;
`endif

    logic                 CLK = 1'b0;
    logic                 RST;
    logic [1:0]           Stage;
    logic                 In_Valid;
    logic                 In_Ready;
    logic signed [DW-1:0] In_Real;
    logic signed [DW-1:0] In_Img;
    logic                 In_Last;
    logic                 Out_Valid;
    logic                 Out_Ready;
    logic signed [DW-1:0] Out_Real;
    logic signed [DW-1:0] Out_Img;
    logic                 Out_Last;
    logic                 Frame_Err;

    ifft_twiddle_rotator #(.DATA_W(16), .FRAME_LEN(8)) dut (
        .CLK       (CLK),
        .RST       (RST),
        .Stage     (Stage),
        .In_Valid  (In_Valid),
        .In_Ready  (In_Ready),
        .In_Real   (In_Real),
        .In_Img    (In_Img),
        .In_Last   (In_Last),
        .Out_Valid (Out_Valid),
        .Out_Ready (Out_Ready),
        .Out_Real  (Out_Real),
        .Out_Img   (Out_Img),
        .Out_Last  (Out_Last),
        .Frame_Err (Frame_Err)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        cplx_t d;
        logic  last;
        int    acc;
    } exp_t;

    exp_t sb[$];
    int   errors = 0;
    int   checks = 0;
    int   cyc = 0;
    int   n_m = 0;
    int   pos = 0;
    logic exp_ferr = 1'b0;
    logic rst_edge = 1'b1;
    bit   mon_en = 1'b0;
    bit   lat_mode = 1'b0;
    bit   rand_rdy = 1'b0;

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic int kidx(input int n, input int st);
        if (st == 0) return (n >= 4) ? n - 4 : 0;
        if (st == 1) return (n == 2 || n == 3 || n == 6 || n == 7) ? 2 * (n % 2) : 0;
        return 0;
    endfunction

    function automatic void twid(input int k, output longint tr, output longint ti);
        case (k)
            0:       begin tr = 1024;  ti = 0;    end
            1:       begin tr = 724;   ti = 724;  end
            2:       begin tr = 0;     ti = 1024; end
            default: begin tr = -724;  ti = 724;  end
        endcase
    endfunction

    // Round half-up (floor of (v + half) / 2^SH) then clamp to the sample range
    function automatic longint rnd_sat(input longint v);
        longint r;
        longint half;
        half = 64'sd1 <<< (SH - 1);
        r = (v + half) >>> SH;
        if (r > 32767) r = 32767;
        if (r < -32768) r = -32768;
        return r;
    endfunction

    // Reference model: tracks frame position and predicts each accepted sample
    initial begin
        forever begin
            @(posedge CLK);
            cyc++;
            rst_edge = RST;
            if (RST) begin
                sb.delete();
                n_m = 0;
                exp_ferr = 1'b0;
            end else begin
                exp_ferr = 1'b0;
                if (In_Valid && In_Ready) begin
                    exp_t   e;
                    longint tr, ti, re, im;
                    twid(kidx(n_m, int'(Stage)), tr, ti);
                    re = longint'(In_Real);
                    im = longint'(In_Img);
                    e.d.re = 16'(rnd_sat(re * tr - im * ti));
                    e.d.im = 16'(rnd_sat(re * ti + im * tr));
                    e.last = In_Last;
                    e.acc  = cyc;
                    sb.push_back(e);
                    exp_ferr = (In_Last && n_m != 7) || (n_m == 7 && !In_Last);
                    n_m = (In_Last || n_m == 7) ? 0 : n_m + 1;
                end
            end
        end
    end

    // Monitor: compares every presented output transfer and per-cycle flags
    initial begin
        logic                 prev_stall;
        logic signed [DW-1:0] prev_re, prev_im;
        logic                 prev_last;
        exp_t                 e;
        prev_stall = 1'b0;
        prev_re    = '0;
        prev_im    = '0;
        prev_last  = 1'b0;
        forever begin
            @(negedge CLK);
            #2;
            if (mon_en) begin
                chk("in_ready_rule", In_Ready, !Out_Valid || Out_Ready);
                chk("frame_err", Frame_Err, exp_ferr);
                if (prev_stall && !rst_edge) begin
                    chk("stall_hold", {Out_Valid, Out_Real, Out_Img, Out_Last},
                        {1'b1, prev_re, prev_im, prev_last});
                end
                if (Out_Valid && Out_Ready) begin
                    if (sb.size() == 0) begin
                        chk("unexpected_output", 1, 0);
                    end else begin
                        e = sb.pop_front();
                        chk("out_real", Out_Real, e.d.re);
                        chk("out_img", Out_Img, e.d.im);
                        chk("out_last", Out_Last, e.last);
                        if (lat_mode) chk("latency", cyc - e.acc, 1);
                    end
                end
                prev_stall = Out_Valid && !Out_Ready;
                prev_re    = Out_Real;
                prev_im    = Out_Img;
                prev_last  = Out_Last;
            end
        end
    end

    task automatic send(input int re, input int im, input int st, input bit last);
        int guard;
        bit done;
        guard = 0;
        done  = 1'b0;
        while (!done) begin
            @(negedge CLK);
            In_Valid  = 1'b1;
            In_Real   = 16'(re);
            In_Img    = 16'(im);
            Stage     = 2'(st);
            In_Last   = last;
            Out_Ready = rand_rdy ? ($urandom_range(0, 3) != 0) : 1'b1;
            #1;
            if (In_Ready) begin
                @(posedge CLK);
                done = 1'b1;
            end else begin
                guard++;
                if (guard > 100) begin
                    chk("send_timeout", 0, 1);
                    done = 1'b1;
                end
            end
        end
        pos = (last || pos == 7) ? 0 : pos + 1;
    endtask

    task automatic idle(input int cycles);
        repeat (cycles) begin
            @(negedge CLK);
            In_Valid  = 1'b0;
            In_Last   = 1'b0;
            Out_Ready = rand_rdy ? ($urandom_range(0, 3) != 0) : 1'b1;
        end
    endtask

    initial begin
        RST = 1'b1; In_Valid = 1'b0; Stage = 2'd0; In_Real = '0; In_Img = '0;
        In_Last = 1'b0; Out_Ready = 1'b1;
        repeat (3) @(posedge CLK);
        @(negedge CLK);
        RST = 1'b0;
        #1;
        chk("rst_out_valid", Out_Valid, 0);
        chk("rst_out_real", Out_Real, 0);
        chk("rst_out_img", Out_Img, 0);
        chk("rst_out_last", Out_Last, 0);
        chk("rst_frame_err", Frame_Err, 0);
        mon_en = 1'b1;

        // Stage 0 frame of (1000,0) at full rate, latency tracked
        lat_mode = 1'b1;
        for (int i = 0; i < 8; i++) send(1000, 0, 0, i == 7);
        idle(3);
        lat_mode = 1'b0;

        // Stage 1 with (0,-1024) at n=3
        for (int i = 0; i < 8; i++) begin
            if (i == 3) send(0, -1024, 1, 1'b0);
            else        send(100 * i, -50, 1, i == 7);
        end
        idle(2);

        // Saturation at stage 0, n=5, both polarities
        for (int i = 0; i < 8; i++) send(i == 5 ? 32767 : 1, i == 5 ? 32767 : 1, 0, i == 7);
        for (int i = 0; i < 8; i++) send(i == 5 ? -32768 : -3, i == 5 ? -32768 : 9, 0, i == 7);
        idle(2);

        // Backpressure with a full pipeline
        send(10, 20, 2, 1'b0);
        send(30, 40, 2, 1'b0);
        repeat (3) begin
            @(negedge CLK);
            In_Valid = 1'b1; In_Real = 16'(20); In_Img = 16'(-2); In_Last = 1'b0;
            Out_Ready = 1'b0;
            #1;
            chk("stall_in_ready", In_Ready, 0);
        end
        for (int i = 2; i < 8; i++) send(10 * i, -i, 2, i == 7);
        idle(3);

        // Early In_Last at n=3, then resync to n=0
        for (int i = 0; i < 4; i++) send(100 + i, 7, 0, i == 3);
        #1;
        chk("ferr_early_last", Frame_Err, 1);
        for (int i = 0; i < 8; i++) send(1234 - i, -567, 0, i == 7);
        // Missing In_Last at n=7
        for (int i = 0; i < 8; i++) send(5 + i, 5, 0, 1'b0);
        #1;
        chk("ferr_missing_last", Frame_Err, 1);
        idle(2);

        // Reset mid-frame with output valid
        for (int i = 0; i < 6; i++) send(1000, 0, 0, 1'b0);
        @(negedge CLK);
        RST = 1'b1; In_Valid = 1'b0; Out_Ready = 1'b1;
        @(negedge CLK);
        #1;
        chk("midrst_out_valid", Out_Valid, 0);
        chk("midrst_frame_err", Frame_Err, 0);
        RST = 1'b0;
        pos = 0;
        for (int i = 0; i < 8; i++) send(1000, 0, 0, i == 7);
        idle(3);

        // Randomized traffic with random backpressure
        rand_rdy = 1'b1;
        for (int i = 0; i < 400; i++) begin
            int  re, im, st;
            bit  lst;
            if ($urandom_range(0, 3) == 0) begin
                re = int'($urandom_range(0, 65535)) - 32768;
                im = int'($urandom_range(0, 65535)) - 32768;
            end else begin
                re = int'($urandom_range(0, 4000)) - 2000;
                im = int'($urandom_range(0, 4000)) - 2000;
            end
            st  = int'($urandom_range(0, 3));
            lst = (pos == 7);
            if ($urandom_range(0, 15) == 0) lst = !lst;
            send(re, im, st, lst);
            if ($urandom_range(0, 3) == 0) idle(int'($urandom_range(1, 3)));
        end
        rand_rdy = 1'b0;
        idle(6);
        chk("scoreboard_empty", sb.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
